sudoku_grid_encoder: RTL

Sequential, parametrised successor of the combinational one-hot-to-digit cell converter. It captures a whole one-hot encoded sudoku grid through a valid/ready handshake and streams the encoded digit codes out LANES cells per beat under backpressure. Each cell is flagged when it is not one-hot, and the flags are counted per grid. The block sits between the grid solver/checker datapath and downstream consumers such as the display/readout logic.

---
 rtl/sudoku_pkg.sv | 18 +
 rtl/sudoku_cell_enc.sv | 24 ++
 rtl/sudoku_grid_encoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku grid encoder: default geometry,
// controller state encoding and the per-cell code width helper.
package sudoku_pkg;

    localparam int DIGITS_DEF = 9;
    localparam int CELLS_DEF  = 81;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Bits needed to hold a digit code 0..digits (0 means empty or invalid)
    function automatic int code_width(input int digits);
        return $clog2(digits + 1);
    endfunction

endpackage

// File: rtl/sudoku_cell_enc.sv
// One-hot cell to digit code converter. A single set bit k yields k+1,
// an empty cell yields 0, and any multi-bit pattern yields 0 with err set.
module sudoku_cell_enc
    import sudoku_pkg::*;
#(
    parameter  int DIGITS = DIGITS_DEF,
    localparam int CW     = code_width(DIGITS)
) (
    input  logic [DIGITS-1:0] bin,
    output logic [CW-1:0]     code,
    output logic              err
);

    // Clearing the lowest set bit leaves something only when two or more bits were set
    always_comb begin
        code = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bin[k]) code = CW'(k + 1);
        end
        err = (bin & (bin - DIGITS'(1))) != '0;
        if (err) code = '0;
    end

endmodule

// File: rtl/sudoku_grid_encoder.sv
// Captures a one-hot sudoku grid and streams its digit codes LANES cells
// per beat under valid/ready backpressure, counting non-one-hot cells.
module sudoku_grid_encoder
    import sudoku_pkg::*;
#(
    parameter  int DIGITS = DIGITS_DEF,
    parameter  int CELLS  = CELLS_DEF,
    parameter  int LANES  = 9,
    localparam int CW     = code_width(DIGITS),
    localparam int BEATS  = CELLS / LANES,
    localparam int IW     = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int EW     = $clog2(CELLS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CELLS*DIGITS-1:0] in_grid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*CW-1:0]     out_code,
    output logic [LANES-1:0]        out_err,
    output logic [IW-1:0]           out_index,
    output logic                    out_last,
    output logic [EW-1:0]           err_count,
    output logic                    done
);

    typedef logic [BEATS-1:0][LANES-1:0][DIGITS-1:0] grid_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);
    localparam logic [EW:0]   SAT      = (EW + 1)'(CELLS);

    state_t                       state_q, state_d;
    grid_t                        grid_q, in_beats, src;
    logic [LANES-1:0][DIGITS-1:0] beat_sel;
    logic [IW-1:0]                idx_q, sel_idx;
    logic [LANES-1:0][CW-1:0]     lane_code, code_q;
    logic [LANES-1:0]             lane_err, err_q;
    logic                         vld_q, last_q, done_q;
    logic [EW-1:0]                cnt_q;
    logic [EW:0]                  cnt_sum;
    logic                         accept, beat_hs, last_hs;

    assign in_beats = in_grid;

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and handshake decode; out_valid is always high in SEND
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        beat_hs  = 1'b0;
        last_hs  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    beat_hs = 1'b1;
                    if (last_q) begin
                        last_hs = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat 0 comes straight from the input on accept, later beats from the captured grid
    always_comb begin
        src     = grid_q;
        sel_idx = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        if (accept) begin
            src     = in_beats;
            sel_idx = '0;
        end
    end

    assign beat_sel = src[sel_idx];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        sudoku_cell_enc #(.DIGITS(DIGITS)) u_enc (
            .bin  (beat_sel[j]),
            .code (lane_code[j]),
            .err  (lane_err[j])
        );
    end

    // Running flag count including the beat currently being handed off
    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        for (int j = 0; j < LANES; j++) begin
            cnt_sum = cnt_sum + (EW + 1)'(err_q[j]);
        end
    end

    // Output registers, grid capture and flag counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grid_q <= '0;
            code_q <= '0;
            err_q  <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= last_hs;
            if (accept) grid_q <= in_beats;
            if (accept || (beat_hs && !last_q)) begin
                code_q <= lane_code;
                err_q  <= lane_err;
                idx_q  <= sel_idx;
                last_q <= (sel_idx == LAST_IDX);
                vld_q  <= 1'b1;
            end else if (last_hs) begin
                vld_q  <= 1'b0;
                last_q <= 1'b0;
            end
            if (accept)       cnt_q <= '0;
            else if (beat_hs) cnt_q <= (cnt_sum > SAT) ? SAT[EW-1:0] : cnt_sum[EW-1:0];
        end
    end

    assign out_valid = vld_q;
    assign out_code  = code_q;
    assign out_err   = err_q;
    assign out_index = idx_q;
    assign out_last  = last_q;
    assign err_count = cnt_q;
    assign done      = done_q;

endmodule
